id_stage_hz: RTL
================

# id_stage_hz

Parametrised decode stage for the pipelined MIPS datapath. It contains the register file with optional write-to-read bypass, sign/zero extension, and load-use hazard detection, and it drives the registered ID/EX pipeline boundary.

- Successor to the flat decode wiring: the ID/EX register, bubble insertion and flush now live inside the stage.
- Downstream EX logic sees only registered values.

## Interface
Parameters:
- DATA_W, 32, datapath/register width
- ADDR_W, 5, register address width; register count is 2**ADDR_W
- CTRL_W, 16, width of the packed control word from the datapath controller

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high; clears register file and ID/EX register
- Instr  in  32  IF/ID instruction
- PCI  in  DATA_W  IF/ID PC+4
- CtrlIn  in  CTRL_W  packed control word for Instr (controller output)
- SignExt  in  1  1 = sign-extend Instr[15:0], 0 = zero-extend
- WbEn  in  1  write-back enable (RegWrite AND valid)
- WbAddr  in  ADDR_W  write-back register
- WbData  in  DATA_W  write-back data
- Flush  in  1  squash the instruction in ID (taken branch/jump)
- Stall  out  1  hold PC and IF/ID this cycle (combinational)
- ExValid  out  1  ID/EX slot holds a real instruction
- ExCtrl  out  CTRL_W  registered control word
- ExRD1, ExRD2  out  DATA_W  registered read data (rs, rt)
- ExImm  out  DATA_W  registered extended immediate
- ExRs, ExRt, ExRd  out  ADDR_W  registered register fields
- ExPCI  out  DATA_W  registered PC+4

## Operation
- Register file
  - Two combinational reads, addressed by Instr[25:21] (rs) and Instr[20:16] (rt); low ADDR_W bits are used.
  - One synchronous write when WbEn=1 and WbAddr!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Immediate: Instr[15:0] is sign- or zero-extended to DATA_W per SignExt.
- Load-use hazard: `Hazard = ExValid & ExCtrl[CTRL_MEMREAD] & (ExRt!=0) & (ExRt==rs | ExRt==rt)`.
  - rs and rt are both compared regardless of instruction format (conservative).
- `Stall = Hazard & ~Flush`.
- ID/EX update on each edge, in priority order:
  1. Rst: all ExX = 0.
  2. Flush or Hazard: bubble — ExValid=0 and ExCtrl=0. Data fields are don't-care; they are loaded with the current values.
  3. Otherwise: ExValid=1 and all fields load from the current decode.
- The stage holds no FSM beyond the ID/EX register. The register file plus ID/EX register form the state.

## Timing
- Reset values:
  - Every output register is 0.
  - All 2**ADDR_W registers are 0.
  - Stall is 0, since ExValid=0.
- Decode-to-ExX latency: 1 cycle.
- A write with WbEn at edge N is readable by the combinational read after edge N.
- Same-cycle write/read of the same register:
  - Without the bypass, the old value is captured into ExRD.
  - With the bypass, see Configuration.
- A stall lasts exactly 1 cycle per load: the bubble clears ExValid, so the hazard drops the next cycle.
- Flush and Hazard in the same cycle: bubble inserted, Stall=0.
- Rst asserted mid-stall: outputs clear immediately (asynchronously); Stall drops combinationally.

## Configuration
- ID_BYPASS_EN defined:
  - If WbEn and WbAddr==rs and rs!=0, the rs read returns WbData in the same cycle. rt is handled likewise.
  - ExRD1/ExRD2 capture the value being written.
- ID_BYPASS_EN undefined: plain read of stored contents. Integration then relies on a negedge-write or a forwarding unit.

## Structure
- Shared package `icarus_pkg`:
  - CTRL_W
  - bit-index constants CTRL_MEMREAD, CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_BRANCH
  - DATA_W/ADDR_W defaults
- Sub-module `regfile_param`:
  - parameters DATA_W, ADDR_W; async-reset array
  - contains the ID_BYPASS_EN bypass logic
- Hazard compare, extension and ID/EX register stay in the top.

## Test plan
- Reset: assert Rst mid-run → all ExX=0, Stall=0; then read r1..r31 → all 0.
- Write/read: WbEn=1, WbAddr=5, WbData=0xDEADBEEF, then Instr with rs=5 → ExRD1=0xDEADBEEF one edge later. Same with WbAddr=0 → reads 0.
- Load-use: lw writing rt=8 enters EX (CtrlIn MemRead=1); next Instr has rs=8 → Stall=1 for one cycle, then ExValid=0, ExCtrl=0. Next cycle Stall=0 and the dependent instruction loads with ExValid=1.
- Hazard + Flush same cycle → Stall=0, bubble inserted.
- Bypass (ID_BYPASS_EN defined): WbEn=1, WbAddr=9, WbData=0x1234 in the same cycle as rt=9 → ExRD2=0x1234. Undefined → ExRD2 = old value.
- Extension: Instr[15:0]=0x8001 → ExImm=0xFFFF8001 with SignExt=1, 0x00008001 with SignExt=0.

Source files
------------

// File: rtl/icarus_pkg.sv
// Shared definitions for the pipelined MIPS datapath: default widths and
// bit positions inside the packed controller word.
package icarus_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CTRL_W = 16;

   // Bit positions inside the packed control word
   localparam int CTRL_MEMREAD  = 0;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_BRANCH   = 3;

endpackage

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational reads, one synchronous write,
// register 0 hard-wired to zero, whole array cleared by asynchronous reset.
// Optional feature macro: ID_BYPASS_EN (write data forwarded to same-cycle reads).
module regfile_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              wen,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   localparam int unsigned NREG = 2**ADDR_W;

   logic [DATA_W-1:0] mem [NREG];

   // Storage: clear everything on reset, otherwise write any non-zero register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wen && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports: register 0 reads zero, optionally forward the pending write
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) begin
`ifdef ID_BYPASS_EN
         if (wen && (waddr == raddr1)) rdata1 = wdata;
         else                          rdata1 = mem[raddr1];
`else
         rdata1 = mem[raddr1];
`endif
      end
      if (raddr2 != '0) begin
`ifdef ID_BYPASS_EN
         if (wen && (waddr == raddr2)) rdata2 = wdata;
         else                          rdata2 = mem[raddr2];
`else
         rdata2 = mem[raddr2];
`endif
      end
   end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: register file, immediate extension, load-use hazard detection
// and the registered ID/EX pipeline boundary (bubble on flush or hazard).
// Optional feature macro: ID_BYPASS_EN (handled inside regfile_param).
// Assumes ADDR_W <= 5 and DATA_W >= 16.
module id_stage_hz #(
   parameter int DATA_W = icarus_pkg::DATA_W,
   parameter int ADDR_W = icarus_pkg::ADDR_W,
   parameter int CTRL_W = icarus_pkg::CTRL_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [31:0]       Instr,
   input  logic [DATA_W-1:0] PCI,
   input  logic [CTRL_W-1:0] CtrlIn,
   input  logic              SignExt,
   input  logic              WbEn,
   input  logic [ADDR_W-1:0] WbAddr,
   input  logic [DATA_W-1:0] WbData,
   input  logic              Flush,
   output logic              Stall,
   output logic              ExValid,
   output logic [CTRL_W-1:0] ExCtrl,
   output logic [DATA_W-1:0] ExRD1,
   output logic [DATA_W-1:0] ExRD2,
   output logic [DATA_W-1:0] ExImm,
   output logic [ADDR_W-1:0] ExRs,
   output logic [ADDR_W-1:0] ExRt,
   output logic [ADDR_W-1:0] ExRd,
   output logic [DATA_W-1:0] ExPCI
);

   import icarus_pkg::*;

   logic [4:0]        rs_f, rt_f, rd_f;
   logic [ADDR_W-1:0] rs, rt, rd;
   logic [DATA_W-1:0] rd1, rd2, imm;
   logic              hazard;
   logic              bubble;
   logic              unused_opcode;

   assign rs_f = Instr[25:21];
   assign rt_f = Instr[20:16];
   assign rd_f = Instr[15:11];
   assign rs   = rs_f[ADDR_W-1:0];
   assign rt   = rt_f[ADDR_W-1:0];
   assign rd   = rd_f[ADDR_W-1:0];

   // Opcode is decoded by the controller, not here
   assign unused_opcode = ^Instr[31:26];

   regfile_param #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clk    (Clk),
      .rst    (Rst),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rd1),
      .rdata2 (rd2),
      .wen    (WbEn),
      .waddr  (WbAddr),
      .wdata  (WbData)
   );

   // Immediate extension and load-use hazard (rs and rt always compared)
   always_comb begin
      imm = '0;
      if (SignExt) imm = {{(DATA_W-16){Instr[15]}}, Instr[15:0]};
      else         imm = {{(DATA_W-16){1'b0}},      Instr[15:0]};
      hazard = ExValid && ExCtrl[CTRL_MEMREAD] && (ExRt != '0) &&
               ((ExRt == rs) || (ExRt == rt));
      bubble = Flush || hazard;
      Stall  = hazard && !Flush;
   end

   // ID/EX register: bubble clears valid/control only, data fields always load
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ExValid <= 1'b0;
         ExCtrl  <= '0;
         ExRD1   <= '0;
         ExRD2   <= '0;
         ExImm   <= '0;
         ExRs    <= '0;
         ExRt    <= '0;
         ExRd    <= '0;
         ExPCI   <= '0;
      end else begin
         ExValid <= !bubble;
         ExCtrl  <= bubble ? '0 : CtrlIn;
         ExRD1   <= rd1;
         ExRD2   <= rd2;
         ExImm   <= imm;
         ExRs    <= rs;
         ExRt    <= rt;
         ExRd    <= rd;
         ExPCI   <= PCI;
      end
   end

endmodule
